// File: rtl/muldiv_iter_pkg.sv
// Shared definitions for the iterative multiply/divide unit: op codes,
// FSM states, stall encodings and small op-decoding helpers.
package muldiv_iter_pkg;

  typedef enum logic [1:0] {
    MdMultu = 2'b00,
    MdMult  = 2'b01,
    MdDivu  = 2'b10,
    MdDiv   = 2'b11
  } md_op_e;

  typedef enum logic [2:0] {
    StIdle = 3'd0,
    StPrep = 3'd1,
    StCalc = 3'd2,
    StFix  = 3'd3,
    StDone = 3'd4
  } md_state_e;

  // busy -> EX stall request mapping
  localparam logic Stop   = 1'b1;
  localparam logic NoStop = 1'b0;

  function automatic logic op_is_div(input md_op_e op);
    return (op == MdDivu) || (op == MdDiv);
  endfunction

  function automatic logic op_is_signed(input md_op_e op);
    return (op == MdMult) || (op == MdDiv);
  endfunction

endpackage

// File: rtl/muldiv_iter_if.sv
// Request/response bundle between the EX stage (master) and the
// multiply/divide unit (slave).
interface muldiv_iter_if #(
  parameter int unsigned W = 32
);
  logic           start;
  logic [1:0]     op;
  logic [W-1:0]   opa;
  logic [W-1:0]   opb;
  logic           annul;
  logic           busy;
  logic           done;
  logic [2*W-1:0] result;
  logic           div_by_zero;

  modport master (
    output start, op, opa, opb, annul,
    input  busy, done, result, div_by_zero
  );

  modport slave (
    input  start, op, opa, opb, annul,
    output busy, done, result, div_by_zero
  );
endinterface

// File: rtl/muldiv_iter_step.sv
// One radix-2 step, purely combinational.
// MUL: right-shifting shift-add, acc = {partial product high, multiplier/low}.
// DIV: restoring subtract-shift, acc = {partial remainder, dividend/quotient}.
module muldiv_step #(
  parameter int unsigned W = 32
) (
  input  logic           mode_div,
  input  logic [2*W-1:0] acc_in,
  input  logic [W-1:0]   opnd,
  output logic [2*W-1:0] acc_out
);

  logic [W:0] mul_sum;
  logic [W:0] rem_sh;
  logic [W:0] diff;

  // Both step flavours computed in parallel, mode selects the result
  always_comb begin
    mul_sum = {1'b0, acc_in[2*W-1:W]} + (acc_in[0] ? {1'b0, opnd} : '0);
    rem_sh  = {acc_in[2*W-1:W], acc_in[W-1]};
    diff    = rem_sh - {1'b0, opnd};
    if (mode_div) begin
      // remainder < divisor keeps a non-negative diff inside W bits,
      // so diff[W] alone flags the borrow
      if (!diff[W]) begin
        acc_out = {diff[W-1:0], acc_in[W-2:0], 1'b1};
      end else begin
        acc_out = {rem_sh[W-1:0], acc_in[W-2:0], 1'b0};
      end
    end else begin
      acc_out = {mul_sum, acc_in[W-1:1]};
    end
  end

endmodule

// File: rtl/muldiv_iter.sv
// Iterative multiply/divide unit for the EX stage. Operands are reduced to
// magnitudes in PREP, iterated UNROLL radix-2 steps per CALC cycle, and the
// signs are restored in FIX. All outputs come straight from flops.
module muldiv_iter
  import muldiv_iter_pkg::*;
#(
  parameter int unsigned W      = 32,
  parameter int unsigned UNROLL = 1
) (
  input  logic           clk,
  input  logic           rst,
  muldiv_iter_if.slave   bus
);

  localparam int unsigned N  = W / UNROLL;
  localparam int unsigned CW = $clog2(N + 1);

  md_state_e      state_q, state_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  md_op_e         op_q, op_d;
  logic [W-1:0]   opa_q, opa_d;
  logic [W-1:0]   opb_q, opb_d;
  logic [W-1:0]   opnd_q, opnd_d;
  logic [2*W-1:0] acc_q, acc_d;
  logic           neg_q, neg_d;
  logic           rneg_q, rneg_d;
  logic [2*W-1:0] result_q, result_d;
  logic           dbz_q, dbz_d;
  logic           busy_q, busy_d;
  logic           done_q, done_d;

  logic           is_div;
  logic           a_neg, b_neg;
  logic [W-1:0]   a_mag, b_mag;
  logic [W-1:0]   quo_fix, rem_fix;
  logic [2*W-1:0] prod_fix;
  logic [2*W-1:0] chain [UNROLL+1];

  assign is_div   = op_is_div(op_q);
  assign chain[0] = acc_q;

  for (genvar g = 0; g < UNROLL; g++) begin : g_step
    muldiv_step #(.W(W)) u_step (
      .mode_div (is_div),
      .acc_in   (chain[g]),
      .opnd     (opnd_q),
      .acc_out  (chain[g+1])
    );
  end

  // Next-state, datapath and output computation
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    op_d     = op_q;
    opa_d    = opa_q;
    opb_d    = opb_q;
    opnd_d   = opnd_q;
    acc_d    = acc_q;
    neg_d    = neg_q;
    rneg_d   = rneg_q;
    result_d = result_q;
    dbz_d    = dbz_q;

    a_neg    = op_is_signed(op_q) && opa_q[W-1];
    b_neg    = op_is_signed(op_q) && opb_q[W-1];
    a_mag    = a_neg ? -opa_q : opa_q;
    b_mag    = b_neg ? -opb_q : opb_q;
    prod_fix = neg_q ? -acc_q : acc_q;
    quo_fix  = neg_q ? -acc_q[W-1:0] : acc_q[W-1:0];
    rem_fix  = rneg_q ? -acc_q[2*W-1:W] : acc_q[2*W-1:W];

    case (state_q)
      StIdle, StDone: begin
        if (bus.start && !bus.annul) begin
          state_d = StPrep;
          op_d    = md_op_e'(bus.op);
          opa_d   = bus.opa;
          opb_d   = bus.opb;
        end else begin
          state_d = StIdle;
        end
      end
      StPrep: begin
        if (bus.annul) begin
          state_d = StIdle;
        end else begin
          state_d = StCalc;
          cnt_d   = CW'(N);
          neg_d   = a_neg ^ b_neg;
          rneg_d  = a_neg;
          if (is_div) begin
            acc_d  = {{W{1'b0}}, a_mag};
            opnd_d = b_mag;
          end else begin
            acc_d  = {{W{1'b0}}, b_mag};
            opnd_d = a_mag;
          end
        end
      end
      StCalc: begin
        if (bus.annul) begin
          state_d = StIdle;
        end else begin
          acc_d = chain[UNROLL];
          cnt_d = cnt_q - CW'(1);
          if (cnt_q == CW'(1)) begin
            state_d = StFix;
          end
        end
      end
      StFix: begin
        if (bus.annul) begin
          state_d = StIdle;
        end else begin
          state_d = StDone;
          if (is_div && (opb_q == '0)) begin
            result_d = {opa_q, {W{1'b1}}};
            dbz_d    = 1'b1;
          end else if (is_div) begin
            result_d = {rem_fix, quo_fix};
            dbz_d    = 1'b0;
          end else begin
            result_d = prod_fix;
            dbz_d    = 1'b0;
          end
        end
      end
      default: state_d = StIdle;
    endcase

    // Decoded from the next state so busy/done leave the unit registered
    busy_d = (state_d == StPrep || state_d == StCalc || state_d == StFix) ? Stop : NoStop;
    done_d = (state_d == StDone);
  end

  // FSM state register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Counter, operand, datapath and output registers
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q    <= '0;
      op_q     <= MdMultu;
      opa_q    <= '0;
      opb_q    <= '0;
      opnd_q   <= '0;
      acc_q    <= '0;
      neg_q    <= 1'b0;
      rneg_q   <= 1'b0;
      result_q <= '0;
      dbz_q    <= 1'b0;
      busy_q   <= NoStop;
      done_q   <= 1'b0;
    end else begin
      cnt_q    <= cnt_d;
      op_q     <= op_d;
      opa_q    <= opa_d;
      opb_q    <= opb_d;
      opnd_q   <= opnd_d;
      acc_q    <= acc_d;
      neg_q    <= neg_d;
      rneg_q   <= rneg_d;
      result_q <= result_d;
      dbz_q    <= dbz_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  assign bus.busy        = busy_q;
  assign bus.done        = done_q;
  assign bus.result      = result_q;
  assign bus.div_by_zero = dbz_q;

endmodule

// File: tb/tb_muldiv_iter.sv
// Self-checking bench for muldiv_iter: a UNROLL=1 and a UNROLL=4 instance,
// table-driven vectors, hand-written annul/reset/back-to-back sequences and
// a random sweep against a reference model built on native arithmetic.
module tb_muldiv_iter;
  import muldiv_iter_pkg::*;

  localparam int unsigned W    = 32;
  localparam int unsigned LAT1 = 35;
  localparam int unsigned LAT4 = 11;

  typedef struct {
    logic [2*W-1:0] res;
    logic           dbz;
    int unsigned    cyc;
  } exp_t;

  typedef struct {
    logic [1:0]     op;
    logic [W-1:0]   a;
    logic [W-1:0]   b;
    logic [2*W-1:0] res;
    logic           dbz;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  int unsigned cyc = 0;
  int          n_tests = 0;
  int          n_fail = 0;
  exp_t        q1[$];
  exp_t        q4[$];
  vec_t        vt [12];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  muldiv_iter_if #(.W(W)) b1 ();
  muldiv_iter_if #(.W(W)) b4 ();

  muldiv_iter #(.W(W), .UNROLL(1)) dut1 (.clk(clk), .rst(rst), .bus(b1));
  muldiv_iter #(.W(W), .UNROLL(4)) dut4 (.clk(clk), .rst(rst), .bus(b4));

  task automatic chk(input string name, input logic [2*W-1:0] act, input logic [2*W-1:0] req);
    n_tests++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, required 0x%0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  task automatic take_done(input int sel, input logic [2*W-1:0] r, input logic d);
    exp_t e;
    if ((sel == 0 && q1.size() == 0) || (sel == 1 && q4.size() == 0)) begin
      n_tests++;
      n_fail++;
      $display("FAIL unexpected_done dut%0d: got done at cycle %0d, required no done", sel, cyc);
    end else begin
      if (sel == 0) e = q1.pop_front();
      else          e = q4.pop_front();
      chk($sformatf("done_result_dut%0d", sel), r, e.res);
      chk($sformatf("done_dbz_dut%0d", sel), 64'(d), 64'(e.dbz));
      chk($sformatf("done_cycle_dut%0d", sel), 64'(cyc), 64'(e.cyc));
    end
  endtask

  // Scoreboard consumer: every done pulse must match the oldest expectation
  always @(negedge clk) begin
    if (b1.done) take_done(0, b1.result, b1.div_by_zero);
    if (b4.done) take_done(1, b4.result, b4.div_by_zero);
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Called shortly after a rising edge: holds start for this cycle (c0)
  task automatic issue(input int sel, input logic [1:0] op, input logic [W-1:0] a,
                       input logic [W-1:0] b, input logic push,
                       input logic [2*W-1:0] er, input logic ed);
    exp_t e;
    e.res = er;
    e.dbz = ed;
    if (sel == 0) begin
      b1.start = 1'b1; b1.op = op; b1.opa = a; b1.opb = b;
      e.cyc = cyc + LAT1;
      if (push) q1.push_back(e);
    end else begin
      b4.start = 1'b1; b4.op = op; b4.opa = a; b4.opb = b;
      e.cyc = cyc + LAT4;
      if (push) q4.push_back(e);
    end
    step(1);
    if (sel == 0) begin
      b1.start = 1'b0; b1.opa = $urandom; b1.opb = $urandom;
    end else begin
      b4.start = 1'b0; b4.opa = $urandom; b4.opb = $urandom;
    end
  endtask

  task automatic wait_drain(input int sel, input int bound);
    for (int i = 0; i < bound; i++) begin
      if ((sel == 0 && q1.size() == 0) || (sel == 1 && q4.size() == 0)) return;
      step(1);
    end
    n_tests++;
    n_fail++;
    $display("FAIL timeout_dut%0d: got %0d pending results after %0d cycles, required 0",
             sel, (sel == 0) ? q1.size() : q4.size(), bound);
    if (sel == 0) q1.delete();
    else          q4.delete();
  endtask

  function automatic logic [2*W-1:0] ref_model(input logic [1:0] op, input logic [W-1:0] a,
                                               input logic [W-1:0] b, output logic dbz);
    longint         sa, sb, q, r;
    logic [2*W-1:0] p;
    sa  = longint'($signed(a));
    sb  = longint'($signed(b));
    dbz = 1'b0;
    p   = '0;
    case (op)
      2'b00: p = {{W{1'b0}}, a} * {{W{1'b0}}, b};
      2'b01: begin q = sa * sb; p = 64'(q); end
      2'b10: begin
        if (b == '0) begin dbz = 1'b1; p = {a, {W{1'b1}}}; end
        else p = {a % b, a / b};
      end
      default: begin
        if (b == '0) begin dbz = 1'b1; p = {a, {W{1'b1}}}; end
        else begin q = sa / sb; r = sa % sb; p = {r[W-1:0], q[W-1:0]}; end
      end
    endcase
    return p;
  endfunction

  initial begin
    #1000000;
    $display("FAIL watchdog: got no summary by time %0t, required completion", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    int unsigned    bc;
    int unsigned    c0;
    logic [1:0]     rop;
    logic [W-1:0]   ra, rb;
    logic [2*W-1:0] rres;
    logic           rdbz;

    vt[0]  = '{MdMultu, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'hFFFF_FFFE_0000_0001, 1'b0};
    vt[1]  = '{MdMult,  32'hFFFF_FFFD, 32'h0000_0007, 64'hFFFF_FFFF_FFFF_FFEB, 1'b0};
    vt[2]  = '{MdMult,  32'h8000_0000, 32'h8000_0000, 64'h4000_0000_0000_0000, 1'b0};
    vt[3]  = '{MdDiv,   32'hFFFF_FFF9, 32'h0000_0002, 64'hFFFF_FFFF_FFFF_FFFD, 1'b0};
    vt[4]  = '{MdDiv,   32'h0000_0007, 32'hFFFF_FFFE, 64'h0000_0001_FFFF_FFFD, 1'b0};
    vt[5]  = '{MdDivu,  32'h0000_0007, 32'h0000_0002, 64'h0000_0001_0000_0003, 1'b0};
    vt[6]  = '{MdDiv,   32'h8000_0000, 32'hFFFF_FFFF, 64'h0000_0000_8000_0000, 1'b0};
    vt[7]  = '{MdMult,  32'hFFFF_FFFF, 32'h0000_0001, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0};
    vt[8]  = '{MdDiv,   32'hFFFF_FFFB, 32'h0000_0000, 64'hFFFF_FFFB_FFFF_FFFF, 1'b1};
    vt[9]  = '{MdMultu, 32'h0001_0000, 32'h0001_0000, 64'h0000_0001_0000_0000, 1'b0};
    vt[10] = '{MdDiv,   32'hFFFF_FFF8, 32'hFFFF_FFFD, 64'hFFFF_FFFE_0000_0002, 1'b0};
    vt[11] = '{MdDivu,  32'h0000_0005, 32'h0000_0000, 64'h0000_0005_FFFF_FFFF, 1'b1};

    b1.start = 1'b0; b1.annul = 1'b0; b1.op = '0; b1.opa = '0; b1.opb = '0;
    b4.start = 1'b0; b4.annul = 1'b0; b4.op = '0; b4.opa = '0; b4.opb = '0;

    // Reset state
    step(3);
    chk("reset_busy", 64'(b1.busy), 64'd0);
    chk("reset_done", 64'(b1.done), 64'd0);
    chk("reset_result", b1.result, 64'd0);
    chk("reset_dbz", 64'(b1.div_by_zero), 64'd0);
    chk("reset_busy_u4", 64'(b4.busy), 64'd0);
    chk("reset_result_u4", b4.result, 64'd0);
    rst = 1'b0;
    step(1);

    // Table vectors on UNROLL=1, with busy window and done pulse checks
    foreach (vt[i]) begin
      issue(0, vt[i].op, vt[i].a, vt[i].b, 1'b1, vt[i].res, vt[i].dbz);
      bc = 0;
      for (int k = 1; k <= 35; k++) begin
        if (b1.busy) bc++;
        if (k == 35) begin
          chk($sformatf("busy_at_done_v%0d", i), 64'(b1.busy), 64'd0);
          chk($sformatf("done_pulse_v%0d", i), 64'(b1.done), 64'd1);
        end
        step(1);
      end
      chk($sformatf("busy_cycles_v%0d", i), 64'(bc), 64'd34);
      chk($sformatf("done_low_after_v%0d", i), 64'(b1.done), 64'd0);
      chk($sformatf("result_held_v%0d", i), b1.result, vt[i].res);
      wait_drain(0, 5);
    end

    // start together with annul in IDLE is ignored
    b1.start = 1'b1; b1.annul = 1'b1; b1.op = MdMultu; b1.opa = 32'd2; b1.opb = 32'd3;
    step(1);
    b1.start = 1'b0; b1.annul = 1'b0;
    chk("idle_annul_busy", 64'(b1.busy), 64'd0);
    step(2);

    // annul at c0+10 of a DIVU, then a fresh start at c0+12
    c0 = cyc;
    issue(0, MdDivu, 32'd100, 32'd7, 1'b0, '0, 1'b0);
    step(9);
    chk("annul_pre_busy", 64'(b1.busy), 64'd1);
    b1.annul = 1'b1;
    step(1);
    b1.annul = 1'b0;
    chk("annul_cycle", 64'(cyc - c0), 64'd11);
    chk("annul_busy", 64'(b1.busy), 64'd0);
    chk("annul_result_kept", b1.result, vt[11].res);
    chk("annul_dbz_kept", 64'(b1.div_by_zero), 64'(vt[11].dbz));
    step(1);
    issue(0, MdDivu, 32'd1000, 32'd10, 1'b1, 64'h0000_0000_0000_0064, 1'b0);
    chk("restart_start_cycle", 64'(cyc - c0), 64'd13);
    wait_drain(0, 50);

    // rst at c0+5 clears everything in the following cycle
    step(1);
    c0 = cyc;
    issue(0, MdMultu, 32'd9, 32'd9, 1'b0, '0, 1'b0);
    step(4);
    rst = 1'b1;
    step(1);
    chk("rst_mid_busy", 64'(b1.busy), 64'd0);
    chk("rst_mid_done", 64'(b1.done), 64'd0);
    chk("rst_mid_result", b1.result, 64'd0);
    chk("rst_mid_dbz", 64'(b1.div_by_zero), 64'd0);
    rst = 1'b0;
    step(40);

    // UNROLL=4 back-to-back: second start held during DONE
    issue(1, MdMultu, 32'd3, 32'd5, 1'b1, 64'h0000_0000_0000_000F, 1'b0);
    step(10);
    chk("b2b_done_u4", 64'(b4.done), 64'd1);
    chk("b2b_busy_u4", 64'(b4.busy), 64'd0);
    issue(1, MdDivu, 32'd100, 32'd7, 1'b1, 64'h0000_0002_0000_000E, 1'b0);
    wait_drain(1, 20);

    // Random sweep on UNROLL=4 against the reference model
    for (int i = 0; i < 40; i++) begin
      rop = 2'($urandom_range(0, 3));
      ra  = $urandom;
      rb  = $urandom;
      case ($urandom_range(0, 7))
        0: rb = '0;
        1: begin ra = 32'h8000_0000; rb = 32'hFFFF_FFFF; end
        2: rb = $urandom_range(1, 15);
        3: ra = $urandom_range(0, 1000);
        default: ;
      endcase
      rres = ref_model(rop, ra, rb, rdbz);
      issue(1, rop, ra, rb, 1'b1, rres, rdbz);
      wait_drain(1, 20);
    end

    step(3);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
